// File: rtl/i2s_rx_frontend.sv
// rtl/i2s_rx_frontend.sv - I2S receiver: oversampled sck/lrclk/sdin, stereo pair deserialiser.
// Optional saturating framing-error counter built when I2S_RX_ERRCNT_EN is defined.
module i2s_rx_frontend #(
  parameter int DW          = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic          m_clk,
  input  logic          rst,
  input  logic          i2s_sck,
  input  logic          i2s_lrclk,
  input  logic          i2s_sdin,
  output logic [DW-1:0] dout_l,
  output logic [DW-1:0] dout_r,
  output logic          dout_valid,
  output logic          frame_err,
  output logic [7:0]    err_cnt
);

  localparam int CW = $clog2(DW);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync, lr_sync, sd_sync;
  logic                   sck_d, rise, lr_q, sd_q;

  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      lr_sync  <= '0;
      sd_sync  <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2s_sck};
      lr_sync  <= {lr_sync[SYNC_STAGES-2:0], i2s_lrclk};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2s_sdin};
    end
  end

  // Rise detect is registered together with lrclk/sdin so all three stay aligned.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      sck_d <= 1'b0;
      rise  <= 1'b0;
      lr_q  <= 1'b0;
      sd_q  <= 1'b0;
    end else begin
      sck_d <= sck_sync[SYNC_STAGES-1];
      rise  <= sck_sync[SYNC_STAGES-1] & ~sck_d;
      lr_q  <= lr_sync[SYNC_STAGES-1];
      sd_q  <= sd_sync[SYNC_STAGES-1];
    end
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          ch, l_ok, lr_prev, primed;
  logic [DW-2:0] sh;
  logic [DW-1:0] l_hold;
  logic [DW-1:0] word;
  logic          ws_edge, last;

  assign word    = {sh, sd_q};
  assign ws_edge = (lr_q != lr_prev);
  assign last    = (cnt == CW'(DW-1));

  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ch         <= 1'b0;
      l_ok       <= 1'b0;
      lr_prev    <= 1'b0;
      primed     <= 1'b0;
      sh         <= '0;
      l_hold     <= '0;
      dout_l     <= '0;
      dout_r     <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rise) begin
        lr_prev <= lr_q;
        case (state)
          S_IDLE: begin
            if (!primed) begin
              primed <= 1'b1;
            end else if (ws_edge) begin
              state <= S_SHIFT;
              cnt   <= '0;
              ch    <= lr_q;
            end
          end
          S_SHIFT: begin
            sh <= word[DW-2:0];
            // A DW-wide slot ends on the edge rise itself: finish the word before restarting.
            if (last) begin
              if (!ch) begin
                l_hold <= word;
                l_ok   <= 1'b1;
              end else if (l_ok) begin
                dout_l     <= l_hold;
                dout_r     <= word;
                dout_valid <= 1'b1;
                l_ok       <= 1'b0;
              end else begin
                frame_err <= 1'b1;
              end
              if (ws_edge) begin
                cnt <= '0;
                ch  <= lr_q;
              end else begin
                state <= S_HOLD;
              end
            end else if (ws_edge) begin
              frame_err <= 1'b1;
              l_ok      <= 1'b0;
              cnt       <= '0;
              ch        <= lr_q;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_HOLD: begin
            if (ws_edge) begin
              state <= S_SHIFT;
              cnt   <= '0;
              ch    <= lr_q;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef I2S_RX_ERRCNT_EN
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (frame_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// tb/tb_i2s_rx_frontend.sv - directed bench for i2s_rx_frontend (honours I2S_RX_ERRCNT_EN).
module tb_i2s_rx_frontend;
  localparam int DW = 24;
  localparam int SS = 2;
`ifdef I2S_RX_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic          m_clk = 1'b0;
  logic          rst = 1'b1;
  logic          i2s_sck = 1'b0;
  logic          i2s_lrclk = 1'b0;
  logic          i2s_sdin = 1'b0;
  logic [DW-1:0] dout_l, dout_r;
  logic          dout_valid, frame_err;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0, rise_cyc = 0, lat = -1;
  int vcnt = 0, fcnt = 0, both = 0, nz = 0;
  int half = 2;
  int v0, f0, b;
  logic [DW-1:0] vl_last = '0, vr_last = '0;
  logic [DW-1:0] ql[$], qr[$];
  logic [DW-1:0] exp_l[3], exp_r[3];

  i2s_rx_frontend #(.DW(DW), .SYNC_STAGES(SS)) dut (
    .m_clk(m_clk), .rst(rst), .i2s_sck(i2s_sck), .i2s_lrclk(i2s_lrclk),
    .i2s_sdin(i2s_sdin), .dout_l(dout_l), .dout_r(dout_r),
    .dout_valid(dout_valid), .frame_err(frame_err), .err_cnt(err_cnt)
  );

  always #10 m_clk = ~m_clk;

  initial begin : monitor
    forever begin
      @(posedge m_clk);
      cyc++;
      #1;
      if (dout_valid) begin
        vcnt++;
        lat = cyc - rise_cyc;
        vl_last = dout_l;
        vr_last = dout_r;
        ql.push_back(dout_l);
        qr.push_back(dout_r);
      end
      if (frame_err) fcnt++;
      if (dout_valid && frame_err) both++;
      if (rst && ((dout_l != '0) || (dout_r != '0) || dout_valid || frame_err || (err_cnt != 8'd0)))
        nz++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge m_clk);
      #2;
    end
  endtask

  task automatic bit_clk(input logic lr, input logic d);
    i2s_lrclk = lr;
    i2s_sdin  = d;
    tick(half);
    i2s_sck  = 1'b1;
    rise_cyc = cyc;
    tick(half);
    i2s_sck = 1'b0;
  endtask

  // lrclk flips one bit before the next slot's MSB, as on a real I2S link.
  task automatic send_slot(input logic lr, input logic [DW-1:0] w, input int width, input int first);
    for (int j = first; j < width; j++)
      bit_clk((j == width - 1) ? ~lr : lr, (j < DW) ? w[DW-1-j] : 1'b0);
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int width);
    send_slot(1'b0, l, width, 0);
    send_slot(1'b1, r, width, 0);
  endtask

  initial begin : stim
    // reset held while the link toggles
    send_slot(1'b0, 24'hF0F0F0, 10, 0);
    send_slot(1'b1, 24'h0F0F0F, 10, 0);
    tick(4);
    check("rst_nonzero_cycles", nz, 0);
    check("rst_dout_l", dout_l, 0);
    check("rst_dout_r", dout_r, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    tick(2);

    // 64fs nominal, 16 m_clk per bit
    half = 8;
    send_slot(1'b1, '0, 4, 0);
    v0 = vcnt; f0 = fcnt;
    frame(24'h123456, 24'hABCDEF, 32);
    check("nom_pulses", vcnt - v0, 1);
    check("nom_l", vl_last, 24'h123456);
    check("nom_r", vr_last, 24'hABCDEF);
    check("nom_latency", lat, SS + 2);
    check("nom_ferr", fcnt - f0, 0);

    // 48fs back-to-back
    half = 2;
    v0 = vcnt; f0 = fcnt; b = ql.size();
    exp_l = '{24'h000001, 24'h7FFFFF, 24'h555555};
    exp_r = '{24'h800000, 24'hFFFFFF, 24'hAAAAAA};
    for (int i = 0; i < 3; i++) frame(exp_l[i], exp_r[i], 24);
    tick(8);
    check("b2b_pulses", vcnt - v0, 3);
    check("b2b_ferr", fcnt - f0, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_l%0d", i), (b + i < ql.size()) ? ql[b+i] : 'x, exp_l[i]);
      check($sformatf("b2b_r%0d", i), (b + i < qr.size()) ? qr[b+i] : 'x, exp_r[i]);
    end

    // short right slot (16 bits) then a good frame
    v0 = vcnt; f0 = fcnt;
    send_slot(1'b0, 24'h111111, 24, 0);
    send_slot(1'b1, 24'h222222, 16, 0);
    tick(8);
    check("short_no_valid", vcnt - v0, 0);
    check("short_ferr", fcnt - f0, 1);
    frame(24'h654321, 24'h13579B, 24);
    tick(8);
    check("short_next_valid", vcnt - v0, 1);
    check("short_next_l", vl_last, 24'h654321);
    check("short_next_r", vr_last, 24'h13579B);
    check("short_ferr_total", fcnt - f0, 1);
    check("short_err_cnt", err_cnt, ERRCNT ? 1 : 0);

    // reset during bit 10 of the right slot
    send_slot(1'b0, 24'h5A5A5A, 24, 0);
    send_slot(1'b1, 24'h0F0F0F, 10, 0);
    rst = 1'b1;
    bit_clk(1'b1, 1'b0);
    rst = 1'b0;
    check("mid_dout_l", dout_l, 0);
    check("mid_dout_r", dout_r, 0);
    check("mid_err_cnt", err_cnt, 0);
    v0 = vcnt;
    send_slot(1'b1, 24'h0F0F0F, 24, 11);
    tick(8);
    check("mid_no_valid", vcnt - v0, 0);
    frame(24'hC0FFEE, 24'hBADF00, 24);
    tick(8);
    check("mid_valid", vcnt - v0, 1);
    check("mid_l", vl_last, 24'hC0FFEE);
    check("mid_r", vr_last, 24'hBADF00);

    // 300 frames of 16-bit slots: both slots of each frame are short
    f0 = fcnt;
    repeat (300) frame(24'h0F0F0F, 24'hF0F0F0, 16);
    tick(8);
    check("sat_ferr", fcnt - f0, 600);
    check("sat_err_cnt", err_cnt, ERRCNT ? 255 : 0);
    check("valid_and_ferr_overlap", both, 0);
    check("rst_nonzero_total", nz, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
